// File: rtl/jtframe_led_arb.sv
// jtframe_led_arb: fixed-priority arbiter and frame-timed blink sequencer
// for the board status LED.
//
// Ports:
//   rst     in   async active-high reset
//   clk     in   clock, rising edge
//   LVBL    in   vertical blank, active low; falling edge = new frame
//   en      in   LED enable (0 forces the LED dark, arbitration continues)
//   req     in   [3:0] requests, req[3] highest priority
//   mode    in   [7:0] pattern per requester, mode[2i+1:2i]
//   led     out  registered LED pin (lit ^ POL)
//   gnt     out  [1:0] current grant index, valid with gnt_vld
//   gnt_vld out  grant active (ACTIVE or HOLD)
module jtframe_led_arb #(
   parameter logic POL     = 1'b0,
   parameter int   MINHOLD = 15
) (
   input  logic       rst,
   input  logic       clk,
   input  logic       LVBL,
   input  logic       en,
   input  logic [3:0] req,
   input  logic [7:0] mode,
   output logic       led,
   output logic [1:0] gnt,
   output logic       gnt_vld
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACTIVE = 2'd1;
   localparam logic [1:0] HOLD   = 2'd2;

   localparam logic [7:0] HOLD_INIT = 8'(MINHOLD);

   logic [1:0] st, st_nx;
   logic [1:0] gnt_nx;
   logic [7:0] hcnt;
   logic [4:0] pcnt;
   logic       lvbl_l;
   logic       fstb;
   logic       load;
   logic       any;
   logic [1:0] top;
   logic [1:0] msel;
   logic       pat;
   logic       lit;

   assign any     = |req;
   assign gnt_vld = st != IDLE;

   always_comb begin
      top = 2'd0;
      priority case (1'b1)
         req[3]:  top = 2'd3;
         req[2]:  top = 2'd2;
         req[1]:  top = 2'd1;
         default: top = 2'd0;
      endcase
   end

   // A new grant (load) reloads hcnt and restarts the pattern.
   // Returning from HOLD to ACTIVE keeps both counters running.
   always_comb begin
      st_nx  = st;
      gnt_nx = gnt;
      load   = 1'b0;
      if (any && (st == IDLE || top > gnt)) begin
         load   = 1'b1;
         gnt_nx = top;
         st_nx  = ACTIVE;
      end else begin
         case (st)
            ACTIVE: begin
               if (!req[gnt]) begin
                  if (hcnt != 8'd0) begin
                     st_nx = HOLD;
                  end else if (any) begin
                     load   = 1'b1;
                     gnt_nx = top;
                     st_nx  = ACTIVE;
                  end else begin
                     st_nx = IDLE;
                  end
               end
            end
            HOLD: begin
               if (req[gnt]) begin
                  st_nx = ACTIVE;
               end else if (hcnt == 8'd0) begin
                  if (any) begin
                     load   = 1'b1;
                     gnt_nx = top;
                     st_nx  = ACTIVE;
                  end else begin
                     st_nx = IDLE;
                  end
               end
            end
            default: st_nx = IDLE;
         endcase
      end
   end

   assign msel = mode[{gnt, 1'b0} +: 2];

   always_comb begin
      pat = 1'b1;
      case (msel)
         2'd0: pat = 1'b1;
         2'd1: pat = ~pcnt[4];
         2'd2: pat = ~pcnt[2];
         2'd3: pat = pcnt[4:1] == 4'd0;
         default: pat = 1'b1;
      endcase
   end

   assign lit = gnt_vld & en & pat;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lvbl_l <= 1'b1;
         fstb   <= 1'b0;
      end else begin
         lvbl_l <= LVBL;
         fstb   <= ~LVBL & lvbl_l;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st   <= IDLE;
         gnt  <= 2'd0;
         hcnt <= 8'd0;
         pcnt <= 5'd0;
         led  <= POL;
      end else begin
         st  <= st_nx;
         gnt <= gnt_nx;
         led <= lit ^ POL;
         // A grant landing on a frame strobe wins: no decrement.
         if (load) begin
            hcnt <= HOLD_INIT;
            pcnt <= 5'd0;
         end else if (fstb) begin
            if (hcnt != 8'd0) hcnt <= hcnt - 8'd1;
            pcnt <= pcnt + 5'd1;
         end
      end
   end

endmodule

// File: tb/tb_jtframe_led_arb.sv
// Randomized scoreboard bench for jtframe_led_arb.
// Two instances: (POL=0, MINHOLD=3) and (POL=1, MINHOLD=0).
module tb_jtframe_led_arb;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       LVBL = 1'b1;
   logic       en = 1'b1;
   logic [3:0] req = 4'd0;
   logic [7:0] mode = 8'd0;
   logic       led0, led1, gv0, gv1;
   logic [1:0] g0, g1;

   always #5 clk = ~clk;

   jtframe_led_arb #(.POL(1'b0), .MINHOLD(3)) u0 (
      .rst(rst), .clk(clk), .LVBL(LVBL), .en(en), .req(req),
      .mode(mode), .led(led0), .gnt(g0), .gnt_vld(gv0)
   );

   jtframe_led_arb #(.POL(1'b1), .MINHOLD(0)) u1 (
      .rst(rst), .clk(clk), .LVBL(LVBL), .en(en), .req(req),
      .mode(mode), .led(led1), .gnt(g1), .gnt_vld(gv1)
   );

   typedef struct packed {
      logic [1:0] led;
      logic [1:0] vld;
      logic [3:0] gnt;
   } exp_t;

   exp_t q[$];
   int total = 0;
   int bad = 0;

   // reference model: 0 = no grant, 1 = request held, 2 = holding
   int MH[2] = '{3, 0};
   int PL[2] = '{0, 1};
   int m_st[2], m_g[2], m_h[2], m_p[2], m_lvl[2], m_fs[2], m_led[2];

   function automatic int hi_req(logic [3:0] r);
      for (int b = 3; b >= 0; b--) if (r[b]) return b;
      return -1;
   endfunction

   function automatic int lit_of(int md, int p);
      case (md)
         0: return 1;
         1: return (p < 16) ? 1 : 0;
         2: return ((p / 4) % 2 == 0) ? 1 : 0;
         default: return (p < 2) ? 1 : 0;
      endcase
   endfunction

   task automatic m_reset(int i);
      m_st[i] = 0; m_g[i] = 0; m_h[i] = 0; m_p[i] = 0;
      m_lvl[i] = 1; m_fs[i] = 0; m_led[i] = PL[i];
   endtask

   task automatic m_step(int i);
      int top, md, nst, ng;
      bit ld;
      if (rst) begin
         m_reset(i);
         return;
      end
      md = (int'(mode) >> (2 * m_g[i])) % 4;
      m_led[i] = PL[i] ^ ((m_st[i] != 0 && en) ? lit_of(md, m_p[i]) : 0);
      top = hi_req(req);
      nst = m_st[i];
      ng = m_g[i];
      ld = 1'b0;
      if (top >= 0 && (m_st[i] == 0 || top > m_g[i])) begin
         ld = 1'b1;
      end else if (m_st[i] != 0 && req[m_g[i]] == 1'b1) begin
         nst = 1;
      end else if (m_st[i] != 0) begin
         // request gone: linger while hold frames remain
         if (m_h[i] > 0) nst = 2;
         else if (top >= 0) ld = 1'b1;
         else nst = 0;
      end
      if (ld) begin
         nst = 1; ng = top; m_h[i] = MH[i]; m_p[i] = 0;
      end else if (m_fs[i] != 0) begin
         m_h[i] = (m_h[i] > 0) ? m_h[i] - 1 : 0;
         m_p[i] = (m_p[i] + 1) % 32;
      end
      m_st[i] = nst;
      m_g[i] = ng;
      m_fs[i] = (!LVBL && m_lvl[i] != 0) ? 1 : 0;
      m_lvl[i] = LVBL ? 1 : 0;
   endtask

   function automatic exp_t snap();
      exp_t e;
      e = '0;
      for (int i = 0; i < 2; i++) begin
         e.led[i] = m_led[i] != 0;
         e.vld[i] = m_st[i] != 0;
         e.gnt[2*i +: 2] = 2'(m_g[i]);
      end
      return e;
   endfunction

   task automatic chk(string nm, int a, int e);
      total++;
      if (a != e) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at %0t", nm, a, e, $time);
      end
   endtask

   // monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("led0", int'(led0), int'(e.led[0]));
            chk("led1", int'(led1), int'(e.led[1]));
            chk("vld0", int'(gv0), int'(e.vld[0]));
            chk("vld1", int'(gv1), int'(e.vld[1]));
            if (e.vld[0]) chk("gnt0", int'(g0), int'(e.gnt[1:0]));
            if (e.vld[1]) chk("gnt1", int'(g1), int'(e.gnt[3:2]));
         end
      end
   end

   // stimulus
   initial begin
      int rcnt, lv_cnt, rate, pend;
      exp_t e;
      rcnt = 3;
      lv_cnt = 0;
      pend = -1;
      m_reset(0);
      m_reset(1);
      for (int cyc = 0; cyc < 30000; cyc++) begin
         @(posedge clk);
         m_step(0);
         m_step(1);
         q.push_back(snap());
         #1;
         // frames: LVBL low for 2 cycles every 4..11 cycles
         if (lv_cnt == 0) lv_cnt = $urandom_range(4, 11);
         lv_cnt--;
         LVBL = lv_cnt >= 2;
         // alternate busy and calm request phases
         rate = ((cyc / 3000) % 2 == 1) ? 800 : 25;
         if (pend >= 0) begin
            req[pend] = 1'b0;
            pend = -1;
         end
         if ($urandom_range(0, rate - 1) == 0)
            req[$urandom_range(0, 3)] ^= 1'b1;
         if ($urandom_range(0, 4 * rate - 1) == 0) begin
            pend = $urandom_range(0, 3);
            if (req[pend]) pend = -1;
            else req[pend] = 1'b1;
         end
         if ($urandom_range(0, 99) == 0) mode = 8'($urandom);
         if ($urandom_range(0, 199) == 0) en = ~en;
         if (rst) begin
            if (rcnt > 0) rcnt--;
            if (rcnt == 0) rst = 1'b0;
         end else if (cyc == 15000 || $urandom_range(0, 2999) == 0) begin
            // async reset: outputs must clear at once
            rst = 1'b1;
            rcnt = 2;
            m_reset(0);
            m_reset(1);
            e = q.pop_back();
            q.push_back(snap());
         end
      end
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
